cop0_unit: RTL and testbench
============================

# cop0_unit

System coprocessor 0 for the 3-stage MIPS pipeline: the responder for the decoder's MTC0/MFC0 and interrupt handshake. It holds Status, Cause, EPC, Count and Compare, and latches external and timer interrupt sources. It raises InterruptRequest toward the decoder and, on InterruptHandled, saves the resume PC and masks further interrupts until ERET. It sits beside the execute stage and shares its register-number and write-data operands.

## Interface
- COUNT_DIV, 1: clock cycles per Count increment; must be ≥1.
- HANDLER_ADDR, 32'h0000_0180: interrupt vector driven on HandlerPC.
---
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- copWE  in  1  MTC0 write strobe from the decoder.
- RdE  in  5  COP0 register number for MTC0 and MFC0.
- WriteData  in  32  MTC0 data (rt value).
- ReadData  out  32  MFC0 result; combinational from RdE.
- PC_E  in  32  PC at which to resume after the interrupt.
- ExtIrq  in  5  level-sensitive external sources, mapped to Cause.IP[6:2].
- InterruptRequest  out  1  to the decoder.
- InterruptHandled  in  1  single-cycle accept pulse from the decoder.
- Eret  in  1  ERET executing in the execute stage.
- EPC  out  32  current EPC value, used as the ERET target.
- HandlerPC  out  32  constant HANDLER_ADDR.

## Operation
- Register map:
  - Count = 9, Compare = 11, Status = 12, Cause = 13, EPC = 14.
  - Other numbers read 0; writes to them are ignored.
- Status:
  - Bit 0 is IE and bits 15:8 are IM; all other bits read 0.
  - Writes are masked to the IE and IM bits.
- Cause:
  - Bits 15:8 are IP; all other bits read 0 (ExcCode = 0 is interrupt; BD = 0).
  - IP[1:0] are software bits, writable by MTC0.
  - IP[6:2] are the registered ExtIrq; they are read-only.
  - IP7 is timer-pending and is read-only.
- EPC:
  - Written by MTC0.
  - Loaded with PC_E on InterruptHandled.
- Count increments once every COUNT_DIV cycles and wraps from 32'hFFFF_FFFF to 0.
- Timer pending:
  - Set at the edge where Count increments to a value equal to Compare.
  - Cleared by any MTC0 to Compare.
- InterruptRequest = IE & |(IP & IM).
  - It is decoded from registered state only; there is no input-to-output combinational path.
- InterruptHandled:
  - EPC <= PC_E and IE <= 0.
  - InterruptRequest therefore deasserts the next cycle.
- Eret: IE <= 1.
- Simultaneous events, in priority order:
  - InterruptHandled and Eret in the same cycle: InterruptHandled wins, so IE = 0.
  - InterruptHandled and MTC0 Status: IM is taken from the write and IE is forced to 0.
  - InterruptHandled and MTC0 EPC: PC_E wins.
  - MTC0 Count and a tick: the written value wins; no compare match is evaluated that cycle.
  - MTC0 Compare and a match: the clear wins.
- Reset:
  - All registers and the prescaler go to 0, so Status.IE = 0.
  - InterruptRequest = 0, ReadData = 0 (RdE-dependent after reset), EPC = 0.
  - Asserting rst mid-operation discards pending state immediately.

## Timing
- MTC0: visible to ReadData and InterruptRequest one cycle after the copWE edge.
- MFC0: zero latency, combinational read of the current register values.
- ExtIrq edge to InterruptRequest: 1 cycle, given IE = 1 and the IM bit set.
- Timer: request asserts the cycle after the matching tick edge.
- InterruptHandled to InterruptRequest low: 1 cycle.
  - The decoder must not re-accept while the request is held over that cycle; it is qualified by IE already being cleared.
- Eret with a source still pending: request reasserts 1 cycle after Eret.
- Prescaler:
  - Restarts at 0 on reset.
  - Not affected by MTC0 Count.

## Configuration
- COP0_TIMER_EN:
  - Defined: Count, Compare, prescaler and IP7 are implemented.
  - Undefined: Count and Compare read 0 and ignore writes, IP7 is tied to 0, and no prescaler logic is built.

## Structure
- Shared package cop0_pkg holds:
  - Register numbers (COP0_COUNT, COP0_COMPARE, COP0_STATUS, COP0_CAUSE, COP0_EPC).
  - Status and Cause bit positions (IE, IM_LO/HI, IP_LO/HI).
  - The IP7 timer index.
- One sub-module, cop0_timer, contains the prescaler, Count, Compare and pending flag. It is instantiated only under COP0_TIMER_EN.

## Test plan
- Reset, then MFC0 of regs 12, 13 and 14 → each reads 0; InterruptRequest = 0.
- MTC0 Status = 32'h0000_0401 and ExtIrq = 5'b00001 → InterruptRequest = 1 after 1 cycle.
  - Then pulse InterruptHandled with PC_E = 32'h0040_0020 → EPC = 32'h0040_0020, IE = 0, request low next cycle.
- COUNT_DIV = 4, Compare = 3, Status = 32'h0000_8001:
  - Request rises 1 cycle after Count reaches 3 (cycle 12 from start).
  - MTC0 Compare clears IP7 and the request.
- Count written to 32'hFFFF_FFFF → after one tick Count = 0 with no spurious match when Compare ≠ 0.
- Simultaneous InterruptHandled and Eret with IE = 1 → IE = 0 and EPC = PC_E.
  - A later lone Eret with IP still pending → request reasserts 1 cycle later.
- Build without COP0_TIMER_EN → MFC0 Count/Compare read 0 and Cause.IP7 is always 0.

Source files
------------

// File: rtl/cop0_pkg.sv
// Shared COP0 register numbers and Status/Cause field positions.
package cop0_pkg;

  typedef logic [4:0] cop0Reg_t;

  localparam cop0Reg_t COP0_COUNT   = 5'd9;
  localparam cop0Reg_t COP0_COMPARE = 5'd11;
  localparam cop0Reg_t COP0_STATUS  = 5'd12;
  localparam cop0Reg_t COP0_CAUSE   = 5'd13;
  localparam cop0Reg_t COP0_EPC     = 5'd14;

  localparam int IE    = 0;
  localparam int IM_LO = 8;
  localparam int IM_HI = 15;
  localparam int IP_LO = 8;
  localparam int IP_HI = 15;

  // Index of the timer-pending bit within the 8-bit IP field.
  localparam int IP_TIMER = 7;

endpackage

// File: rtl/cop0_timer.sv
// COP0 Count/Compare timer: prescaler, free-running Count and pending flag.
module cop0_timer #(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        countWE,
  input  logic        compareWE,
  input  logic [31:0] wrData,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timerPending
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   countNext;

  assign tick      = (presc == PRESC_LAST);
  assign countNext = count + 32'd1;

  // Prescaler free-runs from reset; MTC0 Count does not realign it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      compare      <= '0;
      timerPending <= 1'b0;
    end else begin
      if (countWE) begin
        count <= wrData;
      end else if (tick) begin
        count <= countNext;
      end

      if (compareWE) begin
        compare <= wrData;
      end

      // A Compare write always clears; a Count write suppresses the match.
      if (compareWE) begin
        timerPending <= 1'b0;
      end else if (tick && !countWE && (countNext == compare)) begin
        timerPending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cop0_unit.sv
// System coprocessor 0: Status/Cause/EPC plus optional timer (COP0_TIMER_EN).
// Interrupt request is decoded purely from registered state.
module cop0_unit
  import cop0_pkg::*;
#(
  parameter int          COUNT_DIV    = 1,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        copWE,
  input  logic [4:0]  RdE,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [31:0] PC_E,
  input  logic [4:0]  ExtIrq,
  output logic        InterruptRequest,
  input  logic        InterruptHandled,
  input  logic        Eret,
  output logic [31:0] EPC,
  output logic [31:0] HandlerPC
);

  logic        ie;
  logic [7:0]  im;
  logic [1:0]  ipSw;
  logic [4:0]  extReg;
  logic [31:0] epc;
  logic [7:0]  ip;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timerPending;

  logic statusWE, causeWE, epcWE;

  assign statusWE = copWE && (RdE == COP0_STATUS);
  assign causeWE  = copWE && (RdE == COP0_CAUSE);
  assign epcWE    = copWE && (RdE == COP0_EPC);

`ifdef COP0_TIMER_EN
  cop0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) uTimer (
    .clk          (clk),
    .rst          (rst),
    .countWE      (copWE && (RdE == COP0_COUNT)),
    .compareWE    (copWE && (RdE == COP0_COMPARE)),
    .wrData       (WriteData),
    .count        (count),
    .compare      (compare),
    .timerPending (timerPending)
  );
`else
  assign count        = '0;
  assign compare      = '0;
  assign timerPending = 1'b0;
`endif

  // Later assignments win: MTC0, then Eret, then InterruptHandled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie     <= 1'b0;
      im     <= '0;
      ipSw   <= '0;
      extReg <= '0;
      epc    <= '0;
    end else begin
      extReg <= ExtIrq;

      if (statusWE) begin
        im <= WriteData[IM_HI:IM_LO];
        ie <= WriteData[IE];
      end
      if (Eret) begin
        ie <= 1'b1;
      end
      if (InterruptHandled) begin
        ie <= 1'b0;
      end

      if (causeWE) begin
        ipSw <= WriteData[IP_LO+1:IP_LO];
      end

      if (epcWE) begin
        epc <= WriteData;
      end
      if (InterruptHandled) begin
        epc <= PC_E;
      end
    end
  end

  assign ip               = {timerPending, extReg, ipSw};
  assign InterruptRequest = ie & |(ip & im);
  assign EPC              = epc;
  assign HandlerPC        = HANDLER_ADDR;

  always_comb begin
    ReadData = '0;
    case (RdE)
      COP0_COUNT:   ReadData = count;
      COP0_COMPARE: ReadData = compare;
      COP0_STATUS: begin
        ReadData[IM_HI:IM_LO] = im;
        ReadData[IE]          = ie;
      end
      COP0_CAUSE:   ReadData[IP_HI:IP_LO] = ip;
      COP0_EPC:     ReadData = epc;
      default:      ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_cop0_unit.sv
// Directed bench for cop0_unit: vector table plus timer/reset sequences.
module tb_cop0_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        copWE = 1'b0;
  logic [4:0]  RdE = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [31:0] PC_E = '0;
  logic [4:0]  ExtIrq = '0;
  logic        InterruptRequest;
  logic        InterruptHandled = 1'b0;
  logic        Eret = 1'b0;
  logic [31:0] EPC;
  logic [31:0] HandlerPC;

  int checks = 0;
  int errors = 0;

  cop0_unit #(
    .COUNT_DIV    (4),
    .HANDLER_ADDR (32'h0000_0180)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .copWE            (copWE),
    .RdE              (RdE),
    .WriteData        (WriteData),
    .ReadData         (ReadData),
    .PC_E             (PC_E),
    .ExtIrq           (ExtIrq),
    .InterruptRequest (InterruptRequest),
    .InterruptHandled (InterruptHandled),
    .Eret             (Eret),
    .EPC              (EPC),
    .HandlerPC        (HandlerPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  ext;
    logic        ih;
    logic        eret;
    logic [31:0] pc;
    logic [4:0]  rdChk;
    logic [31:0] expRead;
    logic        expIrq;
    logic [31:0] expEpc;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    copWE = 1'b0;
    InterruptHandled = 1'b0;
    Eret = 1'b0;
    ExtIrq = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock with the given strobes, then strobes dropped; returns 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                     input logic ih, input logic er, input logic [31:0] pc);
    copWE = we;
    RdE = rd;
    WriteData = wd;
    InterruptHandled = ih;
    Eret = er;
    PC_E = pc;
    @(posedge clk);
    #1;
    copWE = 1'b0;
    InterruptHandled = 1'b0;
    Eret = 1'b0;
  endtask

  task automatic readReg(input string name, input logic [4:0] rd, input logic [31:0] exp);
    RdE = rd;
    #1;
    check(name, ReadData, exp);
  endtask

  initial begin
    //            we    rd     wd            ext      ih    eret  pc            rdChk  expRead       irq   expEpc
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'b00000, 1'b0, 1'b0, 32'h0,        5'd12, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'b00000, 1'b0, 1'b0, 32'h0,        5'd13, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'b00000, 1'b0, 1'b0, 32'h0,        5'd14, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'b00000, 1'b0, 1'b0, 32'h0,       5'd12, 32'h0000_FF01, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 5'd12, 32'h0000_0401, 5'b00001, 1'b0, 1'b0, 32'h0,       5'd12, 32'h0000_0401, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'b00001, 1'b0, 1'b0, 32'h0,        5'd13, 32'h0000_0400, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'b00001, 1'b1, 1'b0, 32'h0040_0020, 5'd14, 32'h0040_0020, 1'b0, 32'h0040_0020};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'b00001, 1'b0, 1'b0, 32'h0,        5'd12, 32'h0000_0400, 1'b0, 32'h0040_0020};
    vecs[8]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'b00001, 1'b0, 1'b0, 32'h0,       5'd13, 32'h0000_0700, 1'b0, 32'h0040_0020};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'b00001, 1'b0, 1'b1, 32'h0,        5'd12, 32'h0000_0401, 1'b1, 32'h0040_0020};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'b00001, 1'b1, 1'b1, 32'h0000_1234, 5'd12, 32'h0000_0400, 1'b0, 32'h0000_1234};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'b00001, 1'b0, 1'b1, 32'h0,        5'd13, 32'h0000_0700, 1'b1, 32'h0000_1234};
    vecs[12] = '{1'b1, 5'd12, 32'h0000_FF01, 5'b00001, 1'b1, 1'b0, 32'h0000_5678, 5'd12, 32'h0000_FF00, 1'b0, 32'h0000_5678};
    vecs[13] = '{1'b1, 5'd14, 32'hDEAD_BEEF, 5'b00001, 1'b1, 1'b0, 32'h0000_9ABC, 5'd14, 32'h0000_9ABC, 1'b0, 32'h0000_9ABC};
    vecs[14] = '{1'b1, 5'd14, 32'hCAFE_0000, 5'b00001, 1'b0, 1'b0, 32'h0,       5'd14, 32'hCAFE_0000, 1'b0, 32'hCAFE_0000};
    vecs[15] = '{1'b1, 5'd20, 32'hFFFF_FFFF, 5'b00001, 1'b0, 1'b0, 32'h0,       5'd20, 32'h0,        1'b0, 32'hCAFE_0000};
    vecs[16] = '{1'b1, 5'd13, 32'h0,        5'b00000, 1'b0, 1'b0, 32'h0,        5'd13, 32'h0,        1'b0, 32'hCAFE_0000};
    vecs[17] = '{1'b1, 5'd12, 32'h0000_0101, 5'b00000, 1'b0, 1'b0, 32'h0,       5'd12, 32'h0000_0101, 1'b0, 32'hCAFE_0000};
    vecs[18] = '{1'b1, 5'd13, 32'h0000_0100, 5'b00000, 1'b0, 1'b0, 32'h0,       5'd13, 32'h0000_0100, 1'b1, 32'hCAFE_0000};
    vecs[19] = '{1'b1, 5'd12, 32'hFFFF_0000, 5'b00000, 1'b0, 1'b0, 32'h0,       5'd12, 32'h0,        1'b0, 32'hCAFE_0000};

    // Reset state, checked while rst is still asserted.
    #1;
    check("rst_irq", {31'b0, InterruptRequest}, 32'h0);
    check("rst_epc", EPC, 32'h0);
    check("handler_pc", HandlerPC, 32'h0000_0180);
    doReset();

    for (int i = 0; i < 20; i++) begin
      ExtIrq = vecs[i].ext;
      cyc(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].ih, vecs[i].eret, vecs[i].pc);
      readReg($sformatf("vec%0d_read", i), vecs[i].rdChk, vecs[i].expRead);
      check($sformatf("vec%0d_irq", i), {31'b0, InterruptRequest}, {31'b0, vecs[i].expIrq});
      check($sformatf("vec%0d_epc", i), EPC, vecs[i].expEpc);
    end

    // Asynchronous reset mid-cycle drops a live request and EPC at once.
    cyc(1'b1, 5'd12, 32'h0000_0101, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 5'd13, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    check("pre_async_irq", {31'b0, InterruptRequest}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_irq", {31'b0, InterruptRequest}, 32'h0);
    check("async_rst_epc", EPC, 32'h0);
    readReg("async_rst_status", 5'd12, 32'h0);

`ifdef COP0_TIMER_EN
    // Edge k after reset release: prescaler ticks on k = 4, 8, 12, ...
    doReset();
    cyc(1'b1, 5'd11, 32'd3, 1'b0, 1'b0, 32'h0);            // edge 1
    cyc(1'b1, 5'd12, 32'h0000_8001, 1'b0, 1'b0, 32'h0);    // edge 2
    for (int k = 3; k <= 14; k++) begin
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
      check($sformatf("timer_irq_e%0d", k), {31'b0, InterruptRequest}, {31'b0, (k >= 12)});
      if (k == 12) begin
        readReg("timer_count3", 5'd9, 32'd3);
        readReg("timer_cause_ip7", 5'd13, 32'h0000_8000);
      end
    end
    cyc(1'b1, 5'd11, 32'd100, 1'b0, 1'b0, 32'h0);          // edge 15
    check("cmp_clear_irq", {31'b0, InterruptRequest}, 32'h0);
    readReg("cmp_clear_cause", 5'd13, 32'h0);
    readReg("cmp_readback", 5'd11, 32'd100);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);             // edge 16, count 4
    cyc(1'b1, 5'd9, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);     // edge 17
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);             // edge 18
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);             // edge 19
    readReg("wrap_before", 5'd9, 32'hFFFF_FFFF);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);             // edge 20, tick
    readReg("wrap_after", 5'd9, 32'h0);
    readReg("wrap_no_match", 5'd13, 32'h0);
    cyc(1'b1, 5'd11, 32'd5, 1'b0, 1'b0, 32'h0);            // edge 21
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);             // edge 22
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);             // edge 23
    cyc(1'b1, 5'd9, 32'd5, 1'b0, 1'b0, 32'h0);             // edge 24, tick + write
    readReg("cntwr_value", 5'd9, 32'd5);
    readReg("cntwr_no_match", 5'd13, 32'h0);
    check("cntwr_irq", {31'b0, InterruptRequest}, 32'h0);
    repeat (4) cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);  // edge 28, tick
    readReg("cnt_after_tick", 5'd9, 32'd6);
`else
    doReset();
    cyc(1'b1, 5'd12, 32'h0000_FF01, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 5'd9, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 5'd11, 32'h0000_0002, 1'b0, 1'b0, 32'h0);
    readReg("notimer_count", 5'd9, 32'h0);
    readReg("notimer_compare", 5'd11, 32'h0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
      if (k % 5 == 4) begin
        readReg($sformatf("notimer_ip7_%0d", k), 5'd13, 32'h0);
        check($sformatf("notimer_irq_%0d", k), {31'b0, InterruptRequest}, 32'h0);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
